sm4_uart_host: RTL and testbench

Host-side block-to-UART initiator that talks to the SM4 UART endpoint. It takes one 128-bit block, serializes it MSB-first as 16 bytes to a UART byte interface, then collects the 16-byte response into a 128-bit result. It sits in the tester/host FPGA design, beside the team's existing `uart` module, and drives its byte-level ports.

---
 rtl/sm4_uart_host_pkg.sv | 17 +
 rtl/sm4_uart_host_timer.sv | 30 +++
 rtl/sm4_uart_host.sv | 154 +++++++++++++++
 tb/tb_sm4_uart_host.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_uart_host_pkg.sv
// Shared types and sizes for the SM4 UART host initiator (block <-> UART byte stream).
package sm4_uart_host_pkg;

    localparam int BLK_W         = 128;
    localparam int BYTE_W        = 8;
    localparam int BYTES_PER_BLK = 16;
    localparam int IDX_W         = $clog2(BYTES_PER_BLK);
    localparam int CNT_W         = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_TX,
        RECV
    } host_state_t;

endpackage

// File: rtl/sm4_uart_host_timer.sv
// Loadable down-counter with a zero flag; used as the response watchdog when
// SM4_UART_HOST_TIMEOUT_EN is defined.
module sm4_uart_host_timer #(
    parameter int LOAD_VAL = 999_999
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int W = $clog2(LOAD_VAL + 2);

    logic [W-1:0] count;

    // A load always wins over counting; the counter parks at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= W'(LOAD_VAL);
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sm4_uart_host.sv
// Host-side initiator: sends a 128-bit block MSB-first as 16 UART bytes and collects
// the 16-byte response. Optional response watchdog: SM4_UART_HOST_TIMEOUT_EN.
module sm4_uart_host #(
    parameter int CLK_F       = 50_000_000,
    parameter int UART_B      = 9600,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] blk_in,
    input  logic         blk_in_valid,
    output logic         blk_in_ready,
    output logic [127:0] blk_out,
    output logic         blk_out_valid,
    output logic         rsp_err,
    output logic         busy,
    output logic         tx_pdvalid,
    output logic [7:0]   tx_pdata,
    input  logic         tx_done,
    input  logic         rx_pdvalid,
    input  logic [7:0]   rx_pdata
);

    import sm4_uart_host_pkg::*;

    // A degenerate clock/baud/timeout setting never accepts a request.
    localparam bit CFG_OK = (UART_B > 0) && (CLK_F >= UART_B) && (TIMEOUT_CYC > 0);

    host_state_t               state;
    logic [BLK_W-1:0]          tx_sh;
    logic [BLK_W-BYTE_W-1:0]   rx_sh;
    logic [BLK_W-1:0]          rx_next;
    logic [IDX_W-1:0]          idx;
    logic [CNT_W-1:0]          rx_cnt;
    logic                      rx_prev;
    logic                      rx_edge;
    logic                      last_tx;

    assign rx_edge = rx_pdvalid & ~rx_prev;
    assign rx_next = {rx_sh, rx_pdata};
    assign last_tx = (idx == IDX_W'(BYTES_PER_BLK - 1));

`ifdef SM4_UART_HOST_TIMEOUT_EN
    logic timer_load;
    logic timer_en;
    logic timer_zero;

    assign timer_load = ((state == WAIT_TX) && tx_done && last_tx) ||
                        ((state == RECV) && rx_edge);
    assign timer_en   = (state == RECV);

    sm4_uart_host_timer #(
        .LOAD_VAL (TIMEOUT_CYC - 1)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .en    (timer_en),
        .zero  (timer_zero)
    );
`else
    assign rsp_err = 1'b0;
`endif

    // Main FSM; every output is registered and set alongside the state transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            tx_sh         <= '0;
            rx_sh         <= '0;
            idx           <= '0;
            rx_cnt        <= '0;
            rx_prev       <= 1'b1;
            blk_out       <= '0;
            blk_out_valid <= 1'b0;
            blk_in_ready  <= 1'b0;
            busy          <= 1'b0;
            tx_pdvalid    <= 1'b0;
            tx_pdata      <= '0;
`ifdef SM4_UART_HOST_TIMEOUT_EN
            rsp_err       <= 1'b0;
`endif
        end else begin
            rx_prev       <= rx_pdvalid;
            blk_out_valid <= 1'b0;
            tx_pdvalid    <= 1'b0;
`ifdef SM4_UART_HOST_TIMEOUT_EN
            rsp_err       <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    blk_in_ready <= 1'b1;
                    busy         <= 1'b0;
                    if (blk_in_ready && blk_in_valid && CFG_OK) begin
                        tx_sh        <= blk_in;
                        idx          <= '0;
                        tx_pdvalid   <= 1'b1;
                        tx_pdata     <= blk_in[BLK_W-1 -: BYTE_W];
                        blk_in_ready <= 1'b0;
                        busy         <= 1'b1;
                        state        <= SEND;
                    end
                end

                SEND: begin
                    state <= WAIT_TX;
                end

                WAIT_TX: begin
                    if (tx_done) begin
                        tx_sh <= tx_sh << BYTE_W;
                        idx   <= idx + 1'b1;
                        if (last_tx) begin
                            rx_cnt <= '0;
                            state  <= RECV;
                        end else begin
                            tx_pdvalid <= 1'b1;
                            tx_pdata   <= tx_sh[BLK_W-BYTE_W-1 -: BYTE_W];
                            state      <= SEND;
                        end
                    end
                end

                RECV: begin
                    // A byte arriving in the timeout cycle takes priority over the error.
                    if (rx_edge) begin
                        rx_sh  <= rx_next[BLK_W-BYTE_W-1:0];
                        rx_cnt <= rx_cnt + 1'b1;
                        if (rx_cnt == CNT_W'(BYTES_PER_BLK - 1)) begin
                            blk_out       <= rx_next;
                            blk_out_valid <= 1'b1;
                            blk_in_ready  <= 1'b1;
                            busy          <= 1'b0;
                            state         <= IDLE;
                        end
                    end
`ifdef SM4_UART_HOST_TIMEOUT_EN
                    else if (timer_zero) begin
                        rsp_err      <= 1'b1;
                        blk_in_ready <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
`endif
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm4_uart_host.sv
// Scoreboard bench for sm4_uart_host: tx bytes and response blocks are queued as
// stimulus is driven and compared when the DUT emits them.
module tb_sm4_uart_host;

    localparam int TO_CYC = 300;
    localparam int TX_LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] blk_in;
    logic         blk_in_valid;
    logic         blk_in_ready;
    logic [127:0] blk_out;
    logic         blk_out_valid;
    logic         rsp_err;
    logic         busy;
    logic         tx_pdvalid;
    logic [7:0]   tx_pdata;
    logic         tx_done;
    logic         rx_pdvalid;
    logic [7:0]   rx_pdata;

    int testsRun    = 0;
    int testsFailed = 0;
    int cycle       = 0;
    int txDoneCount = 0;
    int validPulses = 0;
    int errPulses   = 0;
    int expValid    = 0;
    int txBase      = 0;
    int lastRxCycle = 0;

    logic [7:0]   txExp[$];
    logic [127:0] rxExp[$];
    logic [7:0]   respBytes[16];
    logic [127:0] lastBlk = '0;

    sm4_uart_host #(
        .CLK_F       (50_000_000),
        .UART_B      (9600),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .blk_in        (blk_in),
        .blk_in_valid  (blk_in_valid),
        .blk_in_ready  (blk_in_ready),
        .blk_out       (blk_out),
        .blk_out_valid (blk_out_valid),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .tx_pdvalid    (tx_pdvalid),
        .tx_pdata      (tx_pdata),
        .tx_done       (tx_done),
        .rx_pdvalid    (rx_pdvalid),
        .rx_pdata      (rx_pdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (tx_done) txDoneCount <= txDoneCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expVal);
        testsRun++;
        if (obs !== expVal) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, expVal);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // UART transmitter model: answers each tx strobe with a tx_done pulse TX_LAT cycles later.
    initial begin
        int waitCnt;
        waitCnt = -1;
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (waitCnt == 0) begin
                tx_done = 1'b1;
                waitCnt = -1;
            end else if (waitCnt > 0) begin
                waitCnt--;
            end
            if (tx_pdvalid) waitCnt = TX_LAT;
        end
    end

    // Output monitor: pops the scoreboard whenever the DUT emits a byte or a block.
    initial begin
        logic [7:0]   expByte;
        logic [127:0] expBlk;
        forever begin
            @(posedge clk);
            #1;
            if (tx_pdvalid) begin
                if (txExp.size() > 0) expByte = txExp.pop_front();
                else                  expByte = 'x;
                checkOutput("tx_byte", 128'(tx_pdata), 128'(expByte));
            end
            if (blk_out_valid) begin
                validPulses++;
                if (rxExp.size() > 0) expBlk = rxExp.pop_front();
                else                  expBlk = 'x;
                checkOutput("blk_out", blk_out, expBlk);
            end
            if (rsp_err) errPulses++;
        end
    end

    task automatic applyStimulus(input logic [127:0] blk);
        int guard;
        guard = 0;
        while (!blk_in_ready && guard < 100) begin
            step(1);
            guard++;
        end
        checkOutput("req_ready", 128'(blk_in_ready), 128'd1);
        for (int i = 15; i >= 0; i--) txExp.push_back(blk[i*8 +: 8]);
        txBase       = txDoneCount;
        blk_in       = blk;
        blk_in_valid = 1'b1;
        step(1);
        blk_in_valid = 1'b0;
        checkOutput("first_tx_lat", 128'(tx_pdvalid), 128'd1);
        checkOutput("busy_on", 128'(busy), 128'd1);
    endtask

    task automatic waitTxDone(input int target);
        int guard;
        guard = 0;
        while (txDoneCount < txBase + target && guard < 2000) begin
            step(1);
            guard++;
        end
        checkOutput("tx_done_count", 128'(txDoneCount - txBase), 128'(target));
    endtask

    task automatic fillRandom();
        for (int i = 0; i < 16; i++) respBytes[i] = 8'($urandom_range(0, 255));
    endtask

    // Plays the endpoint: waits for all 16 tx bytes, then returns n response bytes.
    task automatic sendResponse(input int n, input int hold, input bit b2b, input logic [127:0] nextBlk);
        logic [127:0] expBlk;
        expBlk = '0;
        waitTxDone(16);
        checkOutput("tx_drain", 128'(txExp.size()), 128'd0);
        for (int i = 0; i < 16; i++) expBlk = {expBlk[119:0], respBytes[i]};
        if (n == 16) begin
            rxExp.push_back(expBlk);
            expValid++;
            lastBlk = expBlk;
        end
        for (int i = 0; i < n; i++) begin
            rx_pdata    = respBytes[i];
            rx_pdvalid  = 1'b1;
            lastRxCycle = cycle;
            if (b2b && i == n - 1) begin
                step(1);
                checkOutput("b2b_valid", 128'(blk_out_valid), 128'd1);
                checkOutput("b2b_ready", 128'(blk_in_ready), 128'd1);
                rx_pdvalid = 1'b0;
                applyStimulus(nextBlk);
            end else begin
                step(hold);
                rx_pdvalid = 1'b0;
                step(2);
            end
        end
    endtask

    task automatic drainCheck();
        int guard;
        guard = 0;
        while (rxExp.size() > 0 && guard < 20) begin
            step(1);
            guard++;
        end
        step(2);
        checkOutput("rsp_drain", 128'(rxExp.size()), 128'd0);
        checkOutput("valid_count", 128'(validPulses), 128'(expValid));
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        step(3);
        txExp.delete();
        rxExp.delete();
        rst_n = 1'b1;
        step(10);
    endtask

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] blkA;
        logic [127:0] blkB;
        int guard;

        rst_n        = 1'b0;
        blk_in       = '0;
        blk_in_valid = 1'b0;
        rx_pdvalid   = 1'b0;
        rx_pdata     = '0;
        step(3);

        checkOutput("rst_ready", 128'(blk_in_ready), 128'd0);
        checkOutput("rst_blk_out", blk_out, 128'd0);
        checkOutput("rst_valid", 128'(blk_out_valid), 128'd0);
        checkOutput("rst_err", 128'(rsp_err), 128'd0);
        checkOutput("rst_busy", 128'(busy), 128'd0);
        checkOutput("rst_txv", 128'(tx_pdvalid), 128'd0);
        checkOutput("rst_txd", 128'(tx_pdata), 128'd0);
        rst_n = 1'b1;
        step(1);
        checkOutput("ready_after_rst", 128'(blk_in_ready), 128'd1);

        $display("[TB] basic exchange");
        respBytes = '{8'h68, 8'h1e, 8'hdf, 8'h34, 8'hd2, 8'h06, 8'h96, 8'h5e,
                      8'h86, 8'hb3, 8'he9, 8'h4f, 8'h53, 8'h6e, 8'h42, 8'h46};
        applyStimulus(128'h0123456789abcdeffedcba9876543210);
        sendResponse(16, 1, 1'b0, '0);
        drainCheck();
        checkOutput("basic_result", blk_out, 128'h681edf34d206965e86b3e94f536e4246);
        checkOutput("basic_idle", 128'(blk_in_ready), 128'd1);

        $display("[TB] held rx_pdvalid");
        applyStimulus(128'h0123456789abcdeffedcba9876543210);
        sendResponse(16, 5, 1'b0, '0);
        drainCheck();
        checkOutput("held_result", blk_out, 128'h681edf34d206965e86b3e94f536e4246);

        $display("[TB] stray byte and back-to-back");
        blkA = {$urandom, $urandom, $urandom, $urandom};
        blkB = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(blkA);
        waitTxDone(3);
        step(1);
        rx_pdata   = 8'ha5;
        rx_pdvalid = 1'b1;
        step(1);
        rx_pdvalid = 1'b0;
        fillRandom();
        sendResponse(16, 1, 1'b1, blkB);
        fillRandom();
        sendResponse(16, 2, 1'b0, '0);
        drainCheck();

        $display("[TB] response timeout");
        applyStimulus({$urandom, $urandom, $urandom, $urandom});
        fillRandom();
        sendResponse(7, 1, 1'b0, '0);
`ifdef SM4_UART_HOST_TIMEOUT_EN
        guard = 0;
        while (!rsp_err && guard < TO_CYC + 50) begin
            step(1);
            guard++;
        end
        checkOutput("rsp_err_lat", 128'(cycle - lastRxCycle - 1), 128'(TO_CYC));
        step(1);
        checkOutput("rsp_err_pulse", 128'(rsp_err), 128'd0);
        checkOutput("to_ready", 128'(blk_in_ready), 128'd1);
        checkOutput("to_busy", 128'(busy), 128'd0);
        checkOutput("to_err_count", 128'(errPulses), 128'd1);
`else
        step(TO_CYC + 20);
        checkOutput("noto_busy", 128'(busy), 128'd1);
        checkOutput("noto_ready", 128'(blk_in_ready), 128'd0);
        checkOutput("noto_err_count", 128'(errPulses), 128'd0);
`endif
        checkOutput("to_hold", blk_out, lastBlk);
        checkOutput("to_valid_count", 128'(validPulses), 128'(expValid));
`ifndef SM4_UART_HOST_TIMEOUT_EN
        resetDut();
`endif

        $display("[TB] reset mid-transmit");
        applyStimulus({$urandom, $urandom, $urandom, $urandom});
        waitTxDone(5);
        rst_n = 1'b0;
        step(1);
        checkOutput("mid_rst_ready", 128'(blk_in_ready), 128'd0);
        checkOutput("mid_rst_blk_out", blk_out, 128'd0);
        checkOutput("mid_rst_valid", 128'(blk_out_valid), 128'd0);
        checkOutput("mid_rst_err", 128'(rsp_err), 128'd0);
        checkOutput("mid_rst_busy", 128'(busy), 128'd0);
        checkOutput("mid_rst_txv", 128'(tx_pdvalid), 128'd0);
        checkOutput("mid_rst_txd", 128'(tx_pdata), 128'd0);
        txExp.delete();
        step(2);
        rst_n = 1'b1;
        step(10);

        $display("[TB] recovery after reset");
        applyStimulus({$urandom, $urandom, $urandom, $urandom});
        fillRandom();
        sendResponse(16, 1, 1'b0, '0);
        drainCheck();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
